// File: rtl/timer_counter_pkg.sv
// Shared definitions for the multi-channel timer: channel mode encodings and
// the compare-select width helper used to size the CMP_SEL port.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    FREE_RUN     = 2'b00,
    PERIODIC     = 2'b01,
    ONE_SHOT     = 2'b10,
    FREE_RUN_ALT = 2'b11
  } mode_t;

  // A single channel still needs a one-bit select so the port never collapses.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, compare register, one-shot halt flag and match pulse.
// Latency 1 clk from advancing compare hit to MATCH; no backpressure, a tick is never stalled.
module timer_channel
  import timer_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  tick,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [1:0]            mode,
  input  logic                  cmp_we,
  input  logic [DATA_WIDTH-1:0] cmp_data,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  match,
  output logic                  done
);

  localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] compare;
  logic                  advance;
  logic                  hit;

  // done doubles as the halt flag: only a one-shot completion can set it.
  assign advance = tick && enable && !clear && !done;
  assign hit     = (count == compare);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      count   <= '0;
      compare <= '1;
      match   <= 1'b0;
      done    <= 1'b0;
    end else begin
      match <= advance && hit;
      if (cmp_we) begin
        compare <= cmp_data;
      end
      if (clear) begin
        count <= '0;
        done  <= 1'b0;
      end else if (advance) begin
        case (mode_t'(mode))
          PERIODIC: count <= hit ? '0 : count + CNT_ONE;
          ONE_SHOT: begin
            if (hit) begin
              done <= 1'b1;
            end else begin
              count <= count + CNT_ONE;
            end
          end
          default:  count <= count + CNT_ONE;
        endcase
      end else if (cmp_we && done) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_counter_ch.sv
// Multi-channel timer with a shared prescaler feeding CHANNELS independent counters.
// MATCH latency 1 clk after the advancing hit; no backpressure, inputs are sampled every clock.
module timer_counter_ch
  import timer_counter_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                           CLOCK,
  input  logic                           RESET,
  input  logic [CHANNELS-1:0]            ENABLE,
  input  logic [CHANNELS-1:0]            CLEAR,
  input  logic [2*CHANNELS-1:0]          MODE,
  input  logic [PRESCALE_WIDTH-1:0]      PRESCALE,
  input  logic                           CMP_WE,
  input  logic [sel_width(CHANNELS)-1:0] CMP_SEL,
  input  logic [DATA_WIDTH-1:0]          CMP_DATA,
  output logic [CHANNELS*DATA_WIDTH-1:0] DATA,
  output logic [CHANNELS-1:0]            MATCH,
  output logic [CHANNELS-1:0]            DONE
);

  localparam int SEL_W = sel_width(CHANNELS);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic                      tick;

  // Compare with >= so a PRESCALE reduced below the running count ticks at once.
  assign tick = (pre_cnt >= PRESCALE);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_ONE;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic sel_hit;

    // Out-of-range selects match no channel and are silently dropped.
    assign sel_hit = CMP_WE && (CMP_SEL == SEL_W'(i));

    timer_channel #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ch (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .tick     (tick),
      .enable   (ENABLE[i]),
      .clear    (CLEAR[i]),
      .mode     (MODE[2*i +: 2]),
      .cmp_we   (sel_hit),
      .cmp_data (CMP_DATA),
      .count    (DATA[i*DATA_WIDTH +: DATA_WIDTH]),
      .match    (MATCH[i]),
      .done     (DONE[i])
    );
  end

endmodule

// File: tb/tb_timer_counter_ch.sv
// Directed and randomized checks of timer_counter_ch against a per-cycle arithmetic model.
module tb_timer_counter_ch;

  localparam int CH = 5;
  localparam int DW = 16;

  logic             CLOCK;
  logic             RESET;
  logic [CH-1:0]    ENABLE;
  logic [CH-1:0]    CLEAR;
  logic [2*CH-1:0]  MODE;
  logic [7:0]       PRESCALE;
  logic             CMP_WE;
  logic [2:0]       CMP_SEL;
  logic [DW-1:0]    CMP_DATA;
  logic [CH*DW-1:0] DATA;
  logic [CH-1:0]    MATCH;
  logic [CH-1:0]    DONE;

  timer_counter_ch #(
    .DATA_WIDTH(DW),
    .CHANNELS(CH),
    .PRESCALE_WIDTH(8)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .CLEAR    (CLEAR),
    .MODE     (MODE),
    .PRESCALE (PRESCALE),
    .CMP_WE   (CMP_WE),
    .CMP_SEL  (CMP_SEL),
    .CMP_DATA (CMP_DATA),
    .DATA     (DATA),
    .MATCH    (MATCH),
    .DONE     (DONE)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Reference model state.
  int unsigned m_cnt[CH];
  int unsigned m_cmp[CH];
  bit          m_done[CH];
  bit [CH-1:0] m_match;
  int unsigned m_pre;
  int          cyc;

  task automatic check(input string tag, input logic [CH*DW-1:0] obs, input logic [CH*DW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i]  = 0;
      m_cmp[i]  = 32'hFFFF;
      m_done[i] = 1'b0;
    end
    m_match = '0;
    m_pre   = 0;
  endtask

  task automatic check_all(input string tag);
    logic [CH*DW-1:0] ed;
    logic [CH-1:0]    edn;
    ed  = '0;
    edn = '0;
    for (int i = 0; i < CH; i++) begin
      ed[i*DW +: DW] = m_cnt[i][DW-1:0];
      edn[i]         = m_done[i];
    end
    check({tag, "_data"},  DATA, ed);
    check({tag, "_match"}, {{(CH*DW-CH){1'b0}}, MATCH}, {{(CH*DW-CH){1'b0}}, m_match});
    check({tag, "_done"},  {{(CH*DW-CH){1'b0}}, DONE},  {{(CH*DW-CH){1'b0}}, edn});
  endtask

  // Predict one clock edge from the rules, then advance the DUT and optionally compare.
  task automatic step(input bit chk);
    bit tk;
    tk    = (m_pre >= int'(PRESCALE));
    m_pre = tk ? 0 : m_pre + 1;
    for (int i = 0; i < CH; i++) begin
      bit adv;
      bit hit;
      bit wr;
      int md;
      md  = int'(MODE[2*i +: 2]);
      wr  = CMP_WE && (int'(CMP_SEL) == i);
      adv = tk && ENABLE[i] && !CLEAR[i] && !m_done[i];
      hit = (m_cnt[i] == m_cmp[i]);
      m_match[i] = adv && hit;
      if (wr && m_done[i]) m_done[i] = 1'b0;
      if (CLEAR[i]) begin
        m_cnt[i]  = 0;
        m_done[i] = 1'b0;
      end else if (adv) begin
        if (hit && md == 1)      m_cnt[i] = 0;
        else if (hit && md == 2) m_done[i] = 1'b1;
        else                     m_cnt[i] = (m_cnt[i] + 1) % 65536;
      end
      if (wr) m_cmp[i] = int'(CMP_DATA);
    end
    @(posedge CLOCK);
    #1;
    cyc++;
    if (chk) check_all("model");
  endtask

  initial begin
    int first_m;
    int gap;
    int pulses;
    int early;

    cyc      = 0;
    RESET    = 1'b1;
    ENABLE   = '0;
    CLEAR    = '0;
    MODE     = '0;
    PRESCALE = 8'd3;
    CMP_WE   = 1'b0;
    CMP_SEL  = '0;
    CMP_DATA = '0;
    reset_model();

    // Reset state, before and after the first clock edges.
    #2;
    check("rst_data", DATA, '0);
    check("rst_flags", {{(CH*DW-2*CH){1'b0}}, MATCH, DONE}, '0);
    @(negedge CLOCK);
    RESET = 1'b0;

    // Periodic mode with prescale 3 and compare 4: 20-clock period.
    CMP_WE = 1'b1; CMP_SEL = 3'd1; CMP_DATA = 16'd4;
    MODE[3:2] = 2'b01; ENABLE[1] = 1'b1;
    step(1'b1);
    CMP_WE = 1'b0;
    first_m = -1; gap = -1; pulses = 0;
    for (int k = 0; k < 70; k++) begin
      step(1'b1);
      if (MATCH[1]) begin
        pulses++;
        if (first_m < 0) first_m = cyc;
        else if (gap < 0) gap = cyc - first_m;
      end
    end
    check("periodic_gap", 80'(gap), 80'd20);
    check("periodic_pulses", 80'(pulses >= 3), 80'd1);

    // One-shot on ch2, compare 7, prescale 0.
    ENABLE[1] = 1'b0; PRESCALE = 8'd0;
    CMP_WE = 1'b1; CMP_SEL = 3'd2; CMP_DATA = 16'd7;
    MODE[5:4] = 2'b10; CLEAR[2] = 1'b1;
    step(1'b1);
    CMP_WE = 1'b0; CLEAR[2] = 1'b0; ENABLE[2] = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b1);
      if (MATCH[2]) pulses++;
    end
    check("oneshot_pulses", 80'(pulses), 80'd1);
    check("oneshot_hold", 80'(DATA[2*DW +: DW]), 80'd7);
    check("oneshot_done", 80'(DONE[2]), 80'd1);

    // Compare write on a halted one-shot re-arms it without touching the count.
    CMP_WE = 1'b1; CMP_SEL = 3'd2; CMP_DATA = 16'd10;
    step(1'b1);
    CMP_WE = 1'b0;
    check("rearm_done", 80'(DONE[2]), 80'd0);
    check("rearm_count", 80'(DATA[2*DW +: DW]), 80'd7);
    for (int k = 0; k < 6; k++) step(1'b1);
    check("rearm_hold", 80'(DATA[2*DW +: DW]), 80'd10);

    // CLEAR releases the halt and counting resumes from 0.
    CLEAR[2] = 1'b1;
    step(1'b1);
    CLEAR[2] = 1'b0;
    check("clr_count", 80'(DATA[2*DW +: DW]), 80'd0);
    check("clr_done", 80'(DONE[2]), 80'd0);
    for (int k = 0; k < 3; k++) step(1'b1);
    check("clr_resume", 80'(DATA[2*DW +: DW]), 80'd3);
    ENABLE[2] = 1'b0;

    // CLEAR on the match cycle wins: count 0 and no MATCH.
    CMP_WE = 1'b1; CMP_SEL = 3'd3; CMP_DATA = 16'd5;
    MODE[7:6] = 2'b00; CLEAR[3] = 1'b1;
    step(1'b1);
    CMP_WE = 1'b0; CLEAR[3] = 1'b0; ENABLE[3] = 1'b1;
    for (int k = 0; k < 20 && m_cnt[3] != 5; k++) step(1'b1);
    CLEAR[3] = 1'b1;
    step(1'b1);
    CLEAR[3] = 1'b0;
    check("clrmatch_count", 80'(DATA[3*DW +: DW]), 80'd0);
    check("clrmatch_match", 80'(MATCH[3]), 80'd0);

    // Compare write on the match cycle: old compare value decides.
    CMP_WE = 1'b1; CMP_SEL = 3'd0; CMP_DATA = 16'd3;
    MODE[1:0] = 2'b01; CLEAR[0] = 1'b1;
    step(1'b1);
    CMP_WE = 1'b0; CLEAR[0] = 1'b0; ENABLE[0] = 1'b1;
    for (int k = 0; k < 20 && m_cnt[0] != 3; k++) step(1'b1);
    CMP_WE = 1'b1; CMP_SEL = 3'd0; CMP_DATA = 16'd9;
    step(1'b1);
    CMP_WE = 1'b0;
    check("oldcmp_match", 80'(MATCH[0]), 80'd1);
    check("oldcmp_count", 80'(DATA[DW-1:0]), 80'd0);

    // Randomized traffic, including out-of-range compare selects.
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) PRESCALE = 8'($urandom_range(0, 3));
      for (int i = 0; i < CH; i++) begin
        ENABLE[i] = ($urandom_range(0, 3) != 0);
        CLEAR[i]  = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 49) == 0) MODE = 10'($urandom);
      CMP_WE   = ($urandom_range(0, 3) == 0);
      CMP_SEL  = 3'($urandom_range(0, 7));
      CMP_DATA = 16'($urandom_range(0, 12));
      step(1'b1);
    end

    // Asynchronous reset mid-run with everything active.
    ENABLE = '1; CLEAR = '0; CMP_WE = 1'b0; MODE = 10'b10_01_00_10_01;
    PRESCALE = 8'd0;
    for (int k = 0; k < 5; k++) step(1'b1);
    #2;
    RESET = 1'b1;
    #1;
    check("async_data", DATA, '0);
    check("async_flags", {{(CH*DW-2*CH){1'b0}}, MATCH, DONE}, '0);
    reset_model();

    // Full 16-bit wrap from reset; the reset compare value makes 0xFFFF the only match.
    ENABLE = 5'b00011; MODE = 10'b00_00_00_01_00;
    @(negedge CLOCK);
    RESET = 1'b0;
    early = 0;
    for (int k = 0; k < 65535; k++) begin
      step(1'b0);
      if (MATCH != '0) early++;
    end
    check("wrap_no_early_match", 80'(early), 80'd0);
    check("wrap_ffff", 80'(DATA[DW-1:0]), 80'hFFFF);
    check_all("wrap_ffff");
    step(1'b1);
    check("wrap_zero", 80'(DATA[DW-1:0]), 80'd0);
    check("wrap_match", 80'(MATCH), 80'b00011);
    step(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
